// File: rtl/btn_event_fsm_pkg.sv
// btn_event_fsm_pkg: shared button-path types and default tick constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_event_fsm_pkg;

  // Button FSM state encoding, shared with the debouncer and game control logic.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

  // One hold tick is 2^DEF_TICK_N clocks (about 10 ms at 50 MHz).
  localparam int DEF_TICK_N       = 19;
  // Hold ticks from press to long-press (about 500 ms).
  localparam int DEF_LONG_TICKS   = 50;
  // Hold ticks between auto-repeat pulses once held (about 100 ms).
  localparam int DEF_REPEAT_TICKS = 10;

endpackage

// File: rtl/btn_event_fsm_tick_prescaler.sv
// btn_event_fsm_tick_prescaler: free-running TICK_N-bit counter producing a hold tick on wrap.
// Latency: o_tick is combinational, high in the cycle whose clock edge wraps the count to 0.
// Backpressure: none; i_clr synchronously restarts the count at 0.
module btn_event_fsm_tick_prescaler #(
  parameter int TICK_N = 19
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  logic [TICK_N-1:0] r_cnt;

  // Count up every cycle; a clear holds the count at 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // All-ones means the next edge wraps to 0; that edge is the hold tick.
  assign o_tick = (&r_cnt) & ~i_clr;

endmodule

// File: rtl/btn_event_fsm.sv
// btn_event_fsm: debounced key level -> press/release/click/long-press/auto-repeat pulses.
// Latency: every output registered, one cycle after the db edge or hold tick that causes it.
// Backpressure: none; events are single-cycle pulses the consumer must sample.
// Build option: define AUTO_REPEAT_EN to build the auto-repeat counter in HELD.
module btn_event_fsm
  import btn_event_fsm_pkg::*;
#(
  parameter int TICK_N       = DEF_TICK_N,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_db,
  output logic o_press_tick,
  output logic o_release_tick,
  output logic o_click_tick,
  output logic o_long_tick,
  output logic o_long_press,
  output logic o_repeat_tick
);

  localparam int             HW        = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_TICKS - 1);

  // Both thresholds count whole hold ticks; zero would mean an event with no hold time.
  if (LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_event_fsm: LONG_TICKS and REPEAT_TICKS must be >= 1");
  end

  btn_state_t    r_state, w_state_nxt;
  logic          r_db_d;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_press, r_release, r_click, r_long, r_long_press;
  logic          w_press_nxt, w_release_nxt, w_click_nxt, w_long_nxt, w_long_press_nxt;
  logic          w_rise, w_tick;
  logic          w_repeat_nxt;

  assign w_rise = i_db & ~r_db_d;

  // Prescaler sits at 0 while idle so the first hold tick lands exactly 2^TICK_N after press.
  btn_event_fsm_tick_prescaler #(
    .TICK_N (TICK_N)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

`ifdef AUTO_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] r_rep, w_rep_nxt;
  logic          r_repeat;

  // Repeat counter and pulse register, only present in auto-repeat builds.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rep    <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_rep    <= w_rep_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  assign o_repeat_tick = r_repeat;
`else
  assign o_repeat_tick = 1'b0;
`endif

  // State register, previous db level and event registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_db_d       <= 1'b1;      // a key held through reset must be seen low before it counts
      r_hold       <= '0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_click      <= 1'b0;
      r_long       <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_db_d       <= i_db;
      r_hold       <= w_hold_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_click      <= w_click_nxt;
      r_long       <= w_long_nxt;
      r_long_press <= w_long_press_nxt;
    end
  end

  // Next state and next event values; release always wins over a coincident tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_click_nxt      = 1'b0;
    w_long_nxt       = 1'b0;
    w_long_press_nxt = r_long_press;
    w_repeat_nxt     = 1'b0;
`ifdef AUTO_REPEAT_EN
    w_rep_nxt        = r_rep;
`endif
    case (r_state)
      ST_IDLE: begin
        w_hold_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_press_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!i_db) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
          w_click_nxt   = 1'b1;
        end else if (w_tick) begin
          if (r_hold == LONG_LAST) begin
            w_state_nxt      = ST_HELD;
            w_long_nxt       = 1'b1;
            w_long_press_nxt = 1'b1;
            w_hold_nxt       = '0;
`ifdef AUTO_REPEAT_EN
            w_rep_nxt        = '0;
`endif
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!i_db) begin
          w_state_nxt      = ST_IDLE;
          w_release_nxt    = 1'b1;
          w_long_press_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
        end else if (w_tick) begin
          if (r_rep == REP_LAST) begin
            w_repeat_nxt = 1'b1;
            w_rep_nxt    = '0;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_long_press_nxt = 1'b0;
      end
    endcase
  end

  assign o_press_tick   = r_press;
  assign o_release_tick = r_release;
  assign o_click_tick   = r_click;
  assign o_long_tick    = r_long;
  assign o_long_press   = r_long_press;

endmodule
